// File: rtl/writeback_regfile_pkg.sv
// Shared widths, RegWrite encodings and the committed-write payload
// for the write-back stage and register file.
package writeback_regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS);
  localparam int unsigned JAL_REG  = 31;

  typedef enum logic [1:0] {
    RW_NONE = 2'b00,
    RW_WORD = 2'b01,
    RW_BYTE = 2'b10,
    RW_HALF = 2'b11
  } reg_write_e;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_write_t;

endpackage

// File: rtl/writeback_regfile_if.sv
// MEM/WB write-back inputs, decode read ports and the committed-write
// export, bundled between the pipeline (master) and the register file (slave).
interface writeback_regfile_if;
  import writeback_regfile_pkg::*;

  logic              MemToReg;
  logic [1:0]        RegWrite;
  logic              Jal;
  logic [ADDR_W-1:0] RegWriteAddress;
  logic [DATA_W-1:0] ALUResult;
  logic [DATA_W-1:0] PCAdderOut;
  logic [DATA_W-1:0] MemReadData;
  logic [ADDR_W-1:0] ReadAddress1;
  logic [ADDR_W-1:0] ReadAddress2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              WB_WriteEn;
  logic [ADDR_W-1:0] WB_WriteAddr;
  logic [DATA_W-1:0] WB_WriteData;

  modport master (
    output MemToReg, RegWrite, Jal, RegWriteAddress,
    output ALUResult, PCAdderOut, MemReadData,
    output ReadAddress1, ReadAddress2,
    input  ReadData1, ReadData2,
    input  WB_WriteEn, WB_WriteAddr, WB_WriteData
  );

  modport slave (
    input  MemToReg, RegWrite, Jal, RegWriteAddress,
    input  ALUResult, PCAdderOut, MemReadData,
    input  ReadAddress1, ReadAddress2,
    output ReadData1, ReadData2,
    output WB_WriteEn, WB_WriteAddr, WB_WriteData
  );

endinterface

// File: rtl/writeback_regfile_wb_select_extend.sv
// Write-back source select (Jal > MemToReg > ALU), byte/half sign-extension,
// and effective address/enable generation. Purely combinational.
module wb_select_extend
  import writeback_regfile_pkg::*;
(
  input  logic              mem_to_reg,
  input  logic [1:0]        reg_write,
  input  logic              jal,
  input  logic [ADDR_W-1:0] reg_write_address,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] pc_adder_out,
  input  logic [DATA_W-1:0] mem_read_data,
  output wb_write_t         wr_c
);

  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] sized;
  logic [ADDR_W-1:0] addr;

  always_comb begin
    src   = alu_result;
    sized = '0;
    addr  = reg_write_address;
    if (mem_to_reg) src = mem_read_data;
    // Jal redirects source and destination but leaves the enable to RegWrite
    if (jal) begin
      src  = pc_adder_out;
      addr = ADDR_W'(JAL_REG);
    end
    case (reg_write_e'(reg_write))
      RW_BYTE: sized = {{(DATA_W-8){src[7]}}, src[7:0]};
      RW_HALF: sized = {{(DATA_W-16){src[15]}}, src[15:0]};
      default: sized = src;
    endcase
    wr_c.en   = (reg_write != RW_NONE) && (addr != '0);
    wr_c.addr = addr;
    wr_c.data = sized;
  end

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage and 32x32 register file: two combinational read ports with
// same-cycle bypass, and a registered copy of each committed write.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic               Clk,
  input  logic               Reset,
  writeback_regfile_if.slave bus
);

  wb_write_t         wr;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              wb_en_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;

  wb_select_extend u_sel (
    .mem_to_reg        (bus.MemToReg),
    .reg_write         (bus.RegWrite),
    .jal               (bus.Jal),
    .reg_write_address (bus.RegWriteAddress),
    .alu_result        (bus.ALUResult),
    .pc_adder_out      (bus.PCAdderOut),
    .mem_read_data     (bus.MemReadData),
    .wr_c              (wr)
  );

  // Register array; $0 is never enabled so it stays at its reset value
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr.en) begin
      regs[wr.addr] <= wr.data;
    end
  end

  // Read ports; bypass and array contents are both masked while in reset
  always_comb begin
    rd1 = regs[bus.ReadAddress1];
    rd2 = regs[bus.ReadAddress2];
    if (BYPASS_EN && wr.en && (bus.ReadAddress1 == wr.addr)) rd1 = wr.data;
    if (BYPASS_EN && wr.en && (bus.ReadAddress2 == wr.addr)) rd2 = wr.data;
    if (!Reset) begin
      rd1 = '0;
      rd2 = '0;
    end
  end

  // Committed-write export for the forwarding unit
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_en_q <= wr.en;
      if (wr.en) begin
        wb_addr_q <= wr.addr;
        wb_data_q <= wr.data;
      end
    end
  end

  assign bus.ReadData1    = rd1;
  assign bus.ReadData2    = rd2;
  assign bus.WB_WriteEn   = wb_en_q;
  assign bus.WB_WriteAddr = wb_addr_q;
  assign bus.WB_WriteData = wb_data_q;

endmodule
